// File: rtl/fir_ctrl_regs.sv
// -----------------------------------------------------------------------------
// fir_ctrl_regs
//
// AXI-lite register block and tap-RAM arbiter for the FIR engine.
//
// Register map (byte addresses):
//   0x00         ap_ctrl : bit0 ap_start (write 1, self-clearing), bit1 ap_done (RO),
//                          bit2 ap_idle (RO)
//   0x10         data_length (RW, writes ignored while running)
//   0x20 + 4*k   tap coefficient k, k = 0..Tape_Num-1, held in the external tap RAM
//   anything else: writes dropped, reads return 0
//
// The single tap RAM port belongs to AXI-lite while idle and to the engine
// while running.
//
// Ports:
//   axis_clk, axis_rst         clock, asynchronous active-high reset
//   aw*/w*                     AXI-lite write address/data (single-cycle accept)
//   ar*/r*                     AXI-lite read address/data (one read outstanding)
//   tap_WE/EN/Di/A, tap_Do     tap RAM port (tap_Do valid one cycle after a read)
//   eng_start                  one-cycle start pulse to the engine
//   eng_done                   one-cycle completion pulse from the engine
//   eng_tap_idx                tap index the engine reads while running
//   data_length                programmed sample count
//   irq                        only with FIR_CTRL_IRQ_EN defined; mirrors ap_done
//
// Build option: define FIR_CTRL_IRQ_EN to add the irq output. Without it,
// completion is detected by polling 0x00.
// -----------------------------------------------------------------------------
module fir_ctrl_regs #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   eng_start,
  input  logic                   eng_done,
  input  logic [3:0]             eng_tap_idx,
`ifdef FIR_CTRL_IRQ_EN
  output logic                   irq,
`endif
  output logic [pDATA_WIDTH-1:0] data_length
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] TAP_LO    = pADDR_WIDTH'(32);
  localparam logic [pADDR_WIDTH-1:0] TAP_HI    = pADDR_WIDTH'(32 + 4 * (Tape_Num - 1));

  // Word-aligned address inside the coefficient window.
  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TAP_LO) && (a <= TAP_HI) && (a[1:0] == 2'b00);
  endfunction

  // State
  logic [0:0]             state_q, state_d;
  logic                   ap_done_q, ap_done_d;
  logic [pDATA_WIDTH-1:0] data_length_q, data_length_d;
  logic                   eng_start_q, eng_start_d;
  logic                   rvalid_q, rvalid_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   rd_ctrl_q, rd_ctrl_d;   // outstanding read targets 0x00
  logic                   tap_rd_q, tap_rd_d;     // tap RAM data arrives this cycle

  // Decode
  logic                   idle;
  logic                   wr_fire;
  logic                   wr_is_ctrl;
  logic                   wr_is_len;
  logic                   start_acc;
  logic                   tap_wr;
  logic                   rd_conflict;
  logic                   rd_fire;
  logic                   tap_rd;
  logic                   rd_hs;
  logic [pDATA_WIDTH-1:0] reg_rdata;

  always_comb begin
    idle        = (state_q == S_IDLE);
    wr_fire     = awvalid & wvalid;
    wr_is_ctrl  = (awaddr == ADDR_CTRL);
    wr_is_len   = (awaddr == ADDR_LEN);
    start_acc   = wr_fire & wr_is_ctrl & wdata[0] & idle;
    tap_wr      = wr_fire & is_tap(awaddr) & idle;
    // A tap write owns the RAM port this cycle, so a tap read waits one cycle.
    rd_conflict = tap_wr & is_tap(araddr);
    rd_fire     = arvalid & ~rvalid_q & ~rd_conflict;
    tap_rd      = rd_fire & is_tap(araddr) & idle;
    rd_hs       = rvalid_q & rready;
  end

  // Register read mux, sampled at read accept. Tap reads while idle replace
  // this with tap_Do one cycle later; tap reads while running return 0.
  always_comb begin
    reg_rdata = '0;
    if (araddr == ADDR_CTRL) begin
      reg_rdata = {{(pDATA_WIDTH-3){1'b0}}, idle, ap_done_q, 1'b0};
    end else if (araddr == ADDR_LEN) begin
      reg_rdata = data_length_q;
    end
  end

  // Control FSM and writable registers
  always_comb begin
    state_d       = state_q;
    ap_done_d     = ap_done_q;
    data_length_d = data_length_q;
    eng_start_d   = start_acc;

    if (idle) begin
      if (start_acc) begin
        state_d = S_RUN;
      end
    end else if (eng_done) begin
      state_d = S_IDLE;
    end

    // Completion takes priority over a status-read clear landing the same cycle,
    // because that read sampled the status before completion.
    if (!idle && eng_done) begin
      ap_done_d = 1'b1;
    end else if (start_acc) begin
      ap_done_d = 1'b0;
    end else if (rd_hs && rd_ctrl_q) begin
      ap_done_d = 1'b0;
    end

    if (wr_fire && wr_is_len && idle) begin
      data_length_d = wdata;
    end
  end

  // Read channel
  always_comb begin
    rvalid_d  = rvalid_q;
    rd_ctrl_d = rd_ctrl_q;
    rdata_d   = rdata_q;
    tap_rd_d  = tap_rd;

    if (rd_fire) begin
      rvalid_d  = 1'b1;
      rd_ctrl_d = (araddr == ADDR_CTRL);
      rdata_d   = reg_rdata;
    end else if (rd_hs) begin
      rvalid_d  = 1'b0;
    end

    // Capture the RAM word so rdata stays stable while waiting for rready.
    if (tap_rd_q) begin
      rdata_d = tap_Do;
    end
  end

  // Tap RAM port arbitration
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (!idle) begin
      tap_EN = 1'b1;
      tap_A  = {{(pADDR_WIDTH-6){1'b0}}, eng_tap_idx, 2'b00};
    end else if (tap_wr) begin
      tap_EN = 1'b1;
      tap_WE = 4'hf;
      tap_A  = awaddr;
      tap_Di = wdata;
    end else if (tap_rd) begin
      tap_EN = 1'b1;
      tap_A  = araddr;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q       <= S_IDLE;
      ap_done_q     <= 1'b0;
      data_length_q <= '0;
      eng_start_q   <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rd_ctrl_q     <= 1'b0;
      tap_rd_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ap_done_q     <= ap_done_d;
      data_length_q <= data_length_d;
      eng_start_q   <= eng_start_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      rd_ctrl_q     <= rd_ctrl_d;
      tap_rd_q      <= tap_rd_d;
    end
  end

  assign awready     = wr_fire;
  assign wready      = wr_fire;
  assign arready     = rd_fire;
  assign rvalid      = rvalid_q;
  assign rdata       = tap_rd_q ? tap_Do : rdata_q;
  assign eng_start   = eng_start_q;
  assign data_length = data_length_q;
`ifdef FIR_CTRL_IRQ_EN
  assign irq         = ap_done_q;
`endif

endmodule
